// File: rtl/rot_sequencer.sv
// Command sequencer feeding the 4-bit rotator: steps the shift amount modulo 4,
// holding each value for dwell+1 cycles, and pulses done at the end.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a command; cmd_ready high; outputs retain values
//   RUN   | stepping rot_shift; busy high
//   DONE  | one-cycle done pulse; returns to IDLE
module rot_sequencer #(
    parameter int DATA_W  = 4,
    parameter int STEPS_W = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DATA_W-1:0]  cmd_data,
    input  logic [1:0]         cmd_start,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               cmd_dir,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [DATA_W-1:0]  rot_in,
    output logic [1:0]         rot_shift,
    output logic               step_stb,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [STEPS_W-1:0]   steps_left;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_ld;
    logic                 dir;
    logic                 accept;
    logic                 do_count;
    logic                 do_step;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_count   = 1'b0;
        do_step    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // abort wins over both dwell counting and stepping
                if (abort) begin
                    state_next = DONE;
                end else if (dwell_cnt != '0) begin
                    do_count = 1'b1;
                end else if (steps_left == '0) begin
                    state_next = DONE;
                end else begin
                    do_step = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_in     <= '0;
            rot_shift  <= '0;
            step_stb   <= 1'b0;
            steps_left <= '0;
            dwell_cnt  <= '0;
            dwell_ld   <= '0;
            dir        <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            if (accept) begin
                rot_in     <= cmd_data;
                rot_shift  <= cmd_start;
                steps_left <= cmd_steps;
                dwell_cnt  <= cmd_dwell;
                dwell_ld   <= cmd_dwell;
                dir        <= cmd_dir;
            end else if (do_count) begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else if (do_step) begin
                // 2-bit arithmetic gives the modulo-4 wrap in both directions
                rot_shift  <= dir ? (rot_shift - 2'd1) : (rot_shift + 2'd1);
                steps_left <= steps_left - STEPS_W'(1);
                dwell_cnt  <= dwell_ld;
                step_stb   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rot_sequencer.sv
// Scoreboard bench for rot_sequencer: directed commands push hand-computed
// per-cycle expectations; a negedge monitor pops one whenever the DUT is active.
module tb_rot_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic [1:0] cmd_start;
    logic [3:0] cmd_steps;
    logic       cmd_dir;
    logic [7:0] cmd_dwell;
    logic       abort;
    logic [3:0] rot_in;
    logic [1:0] rot_shift;
    logic       step_stb;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       stb;
        logic [3:0] data;
        logic [1:0] shift;
        logic [3:0] q;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   waits;

    rot_sequencer #(.DATA_W(4), .STEPS_W(4), .DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_start (cmd_start),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .cmd_dwell (cmd_dwell),
        .abort     (abort),
        .rot_in    (rot_in),
        .rot_shift (rot_shift),
        .step_stb  (step_stb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // reference rotator (rotate left) standing in for the downstream block
    function automatic logic [3:0] rotl(input logic [3:0] d, input logic [1:0] s);
        logic [7:0] w;
        w = {d, d} << s;
        return w[7:4];
    endfunction

    task automatic exp(input logic b, input logic d, input logic s,
                       input logic [3:0] data, input logic [1:0] sh, input logic [3:0] q);
        rec_t r;
        r.busy = b; r.done = d; r.stb = s; r.data = data; r.shift = sh; r.q = q;
        exp_q.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] s, input logic [3:0] st,
                        input logic dr, input logic [7:0] dw, output int nw);
        cmd_data = d; cmd_start = s; cmd_steps = st; cmd_dir = dr; cmd_dwell = dw;
        cmd_valid = 1'b1;
        nw = 0;
        do begin
            @(negedge clk);
            nw++;
        end while (!cmd_ready && nw < 200);
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got ready=0 required ready=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!cmd_ready || done) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got busy=%0d required idle", busy);
        end
    endtask

    // monitor
    initial begin
        rec_t act;
        rec_t req;
        forever begin
            @(negedge clk);
            if (busy || done || step_stb) begin
                act.busy = busy; act.done = done; act.stb = step_stb;
                act.data = rot_in; act.shift = rot_shift; act.q = rotl(rot_in, rot_shift);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got busy=%0d done=%0d stb=%0d shift=%0d required no activity",
                             busy, done, step_stb, rot_shift);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        n_bad++;
                        $display("FAIL cycle_record: got busy=%0d done=%0d stb=%0d in=%b shift=%0d q=%b required busy=%0d done=%0d stb=%0d in=%b shift=%0d q=%b",
                                 act.busy, act.done, act.stb, act.data, act.shift, act.q,
                                 req.busy, req.done, req.stb, req.data, req.shift, req.q);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_data = '0; cmd_start = '0; cmd_steps = '0; cmd_dir = 1'b0; cmd_dwell = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rot_in, rot_shift, step_stb, busy, done}, 9'd0);
        chk("reset_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", cmd_ready, 1);

        // walk up
        exp(1,0,0, 4'b0001, 0, 4'b0001);
        exp(1,0,1, 4'b0001, 1, 4'b0010);
        exp(1,0,1, 4'b0001, 2, 4'b0100);
        exp(1,0,1, 4'b0001, 3, 4'b1000);
        exp(0,1,0, 4'b0001, 3, 4'b1000);
        send(4'b0001, 2'd0, 4'd3, 1'b0, 8'd0, waits);
        cmd_valid = 1'b0;
        wait_idle();
        chk("retain_in_idle", {rot_in, rot_shift}, {4'b0001, 2'd3});
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_ignored", {cmd_ready, busy, done}, 3'b100);

        // wrap up: 3,0,1
        exp(1,0,0, 4'b0011, 3, 4'b1001);
        exp(1,0,1, 4'b0011, 0, 4'b0011);
        exp(1,0,1, 4'b0011, 1, 4'b0110);
        exp(0,1,0, 4'b0011, 1, 4'b0110);
        send(4'b0011, 2'd3, 4'd2, 1'b0, 8'd0, waits);
        cmd_valid = 1'b0;
        // wrap down: 0,3,2
        exp(1,0,0, 4'b0001, 0, 4'b0001);
        exp(1,0,1, 4'b0001, 3, 4'b1000);
        exp(1,0,1, 4'b0001, 2, 4'b0100);
        exp(0,1,0, 4'b0001, 2, 4'b0100);
        send(4'b0001, 2'd0, 4'd2, 1'b1, 8'd0, waits);
        cmd_valid = 1'b0;

        // dwell: 1 x3, 2 x3, done in cycle 7
        exp(1,0,0, 4'b1000, 1, 4'b0001);
        exp(1,0,0, 4'b1000, 1, 4'b0001);
        exp(1,0,0, 4'b1000, 1, 4'b0001);
        exp(1,0,1, 4'b1000, 2, 4'b0010);
        exp(1,0,0, 4'b1000, 2, 4'b0010);
        exp(1,0,0, 4'b1000, 2, 4'b0010);
        exp(0,1,0, 4'b1000, 2, 4'b0010);
        send(4'b1000, 2'd1, 4'd1, 1'b0, 8'd2, waits);
        cmd_valid = 1'b0;
        wait_idle();

        // zero steps then back-to-back with cmd_valid held
        exp(1,0,0, 4'b0101, 2, 4'b0101);
        exp(0,1,0, 4'b0101, 2, 4'b0101);
        exp(1,0,0, 4'b1100, 0, 4'b1100);
        exp(1,0,0, 4'b1100, 0, 4'b1100);
        exp(1,0,1, 4'b1100, 1, 4'b1001);
        exp(1,0,0, 4'b1100, 1, 4'b1001);
        exp(0,1,0, 4'b1100, 1, 4'b1001);
        send(4'b0101, 2'd2, 4'd0, 1'b0, 8'd0, waits);
        send(4'b1100, 2'd0, 4'd1, 1'b0, 8'd1, waits);
        chk("b2b_accept_after_done", waits, 3);
        for (int i = 0; i < 3; i++) begin
            chk("ready_low_in_run", cmd_ready, 0);
            cmd_data = 4'($urandom); cmd_start = 2'($urandom);
            cmd_steps = 4'($urandom); cmd_dir = 1'($urandom); cmd_dwell = 8'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_idle();

        // abort at RUN cycle 8: shift frozen at start+1
        for (int i = 0; i < 6; i++) exp(1,0,0, 4'b1010, 2, 4'b1010);
        exp(1,0,1, 4'b1010, 3, 4'b0101);
        exp(1,0,0, 4'b1010, 3, 4'b0101);
        exp(0,1,0, 4'b1010, 3, 4'b0101);
        send(4'b1010, 2'd2, 4'd10, 1'b0, 8'd5, waits);
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle();
        chk("abort_retain", {rot_in, rot_shift}, {4'b1010, 2'd3});

        // reset mid-run
        for (int i = 0; i < 3; i++) exp(1,0,0, 4'b1111, 2, 4'b1111);
        send(4'b1111, 2'd2, 4'd5, 1'b0, 8'd3, waits);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_reset_outputs", {rot_in, rot_shift, step_stb, busy, done}, 9'd0);
        chk("midrun_reset_ready", cmd_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_idle", {cmd_ready, busy, done}, 3'b100);

        exp(1,0,0, 4'b0110, 1, 4'b1100);
        exp(1,0,1, 4'b0110, 0, 4'b0110);
        exp(0,1,0, 4'b0110, 0, 4'b0110);
        send(4'b0110, 2'd1, 4'd1, 1'b1, 8'd0, waits);
        cmd_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
